mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the core's instruction-fetch port and load/store data port.
- Allows one outstanding transaction at a time.
- Fixed priority goes to data, with a starvation guard so fetch still makes progress.
- A fetch-flush input from the branch unit (taken BEQ/BNE/JAL redirect) discards a stale in-flight fetch response.

Parameters:
MEM_LATENCY, 1, cycles from memory enable to mem_rdata valid (legal range 1..7)
STARVE_LIMIT, 4, consecutive data grants with fetch waiting before fetch is forced (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
if_req  in  1  fetch request, held until if_gnt
if_addr  in  32  fetch word address
if_flush  in  1  branch redirect: kill outstanding fetch response
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch data valid, one-cycle pulse
if_rdata  out  32  fetch data; 0 when if_rvalid=0
d_req  in  1  data request, held until d_gnt
d_we  in  1  1=store, 0=load
d_be  in  4  store byte enables
d_addr  in  32  data address
d_wdata  in  32  store data
d_gnt  out  1  data accepted this cycle
d_rvalid  out  1  load data valid, or store ack; one-cycle pulse
d_rdata  out  32  load data; 0 for stores and when d_rvalid=0
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_be  out  4  memory byte enables
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after mem_en

Behaviour:
- FSM states:
  - IDLE: may grant.
  - WAIT: counting latency, owner recorded.
  - RESP: response cycle.
- IDLE → WAIT on any grant. WAIT → RESP when the counter reaches MEM_LATENCY-1; with MEM_LATENCY=1 the FSM goes IDLE → RESP directly. RESP → IDLE unconditionally.
- Grant is combinational in IDLE only. Request/grant rules:
  - if_gnt/d_gnt are 0 in WAIT and RESP.
  - A request is accepted when req && gnt.
  - mem_en=1 in the same cycle, with mem_* driven from the granted requester.
- Fetch accesses drive mem_we=0 and mem_be=4'hF.
- mem_en=0 in every cycle without a grant. mem_* outputs are 0 when mem_en=0.
- Arbitration in IDLE:
  - Only one requester: it is granted.
  - Both requesting: d_req wins unless starve_cnt==STARVE_LIMIT, in which case fetch wins.
  - if_flush=1 in IDLE blocks a fetch grant that cycle; a data grant is unaffected.
- Starve counter:
  - Increments on a data grant while if_req=1, saturating at STARVE_LIMIT.
  - Clears on any fetch grant, or on a data grant with if_req=0.
- Timing: a grant at cycle T gives rvalid exactly at T+MEM_LATENCY for the owner. rdata equals mem_rdata in that cycle. The earliest next grant is T+MEM_LATENCY+1.
- Stores produce d_rvalid at the same time (ack) with d_rdata=0.
- Flush:
  - if_flush=1 in any cycle from T+1 through the RESP cycle of a fetch-owned transaction suppresses if_rvalid for it.
  - The FSM still runs the full timing and does not regrant early.
  - if_flush has no effect on data-owned transactions.
- rvalid is never asserted for both ports in the same cycle, and never more than once per grant.
- Reset, at any state including mid-WAIT:
  - Next state is IDLE; starve_cnt=0; flush-kill flag=0.
  - All outputs are 0 while rst=1, and the in-flight response is dropped.
  - The first grant is possible in the first cycle with rst=0.

Test Plan:
- MEM_LATENCY=1, if_req=1, if_addr=0x0000_0004, mem model returns 0x0010_0093 → if_gnt/mem_en=1 with mem_addr=0x4 at T; if_rvalid=1 with if_rdata=0x0010_0093 at T+1; no grant at T+1; regrant possible at T+2.
- Store d_we=1, d_be=4'b0011, d_addr=0x100, d_wdata=0xDEAD_BEEF → mem_we=1, mem_be=0011, mem_wdata=0xDEAD_BEEF at the grant cycle; d_rvalid=1 with d_rdata=0 one cycle later; a following load of 0x100 returns 0x0000_BEEF (memory model was 0).
- if_req and d_req both held high, STARVE_LIMIT=4, MEM_LATENCY=1 → grant order D,D,D,D,I,D,D,D,D,I; each grant is 2 cycles apart.
- Fetch granted, if_flush=1 for one cycle at T+1, MEM_LATENCY=3 → if_rvalid stays 0 at T+3; next grant no earlier than T+4; the new fetch returns data normally.
- MEM_LATENCY=2, d load granted at T, rst=1 at T+1 → d_rvalid=0 at T+2; all outputs 0; after rst drops, starve_cnt=0 and the first request is granted that cycle.
- if_flush=1 in IDLE with only if_req=1 → if_gnt=0, mem_en=0; if_gnt=1 the next cycle after flush deasserts.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Shares one single-port memory between fetch and data ports, one transaction in flight.
// Grant is combinational in IDLE; response follows MEM_LATENCY cycles later; requesters hold req until gnt.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);
  localparam logic [3:0] SLIM   = 4'(STARVE_LIMIT);

  logic [1:0] r_state;
  logic [2:0] r_cnt;
  logic       r_own_d;
  logic       r_we;
  logic       r_kill;
  logic [3:0] r_starve;

  logic w_idle;
  logic w_fetch_ok;
  logic w_gnt_d;
  logic w_gnt_i;
  logic w_resp;

  // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
  always_comb begin
    w_idle     = (r_state == S_IDLE) && !rst;
    w_fetch_ok = if_req && !if_flush;
    w_gnt_d    = w_idle && d_req && (!w_fetch_ok || (r_starve != SLIM));
    w_gnt_i    = w_idle && w_fetch_ok && !w_gnt_d;
    w_resp     = (r_state == S_RESP) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_own_d  <= 1'b0;
      r_we     <= 1'b0;
      r_kill   <= 1'b0;
      r_starve <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_d || w_gnt_i) begin
            r_own_d <= w_gnt_d;
            r_we    <= w_gnt_d && d_we;
            r_kill  <= 1'b0;
            r_cnt   <= 3'd1;
            r_state <= (MEM_LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          // A redirect while the fetch is in flight makes its data stale.
          if (!r_own_d && if_flush) r_kill <= 1'b1;
          if (r_cnt == LAT_M1) r_state <= S_RESP;
          else                 r_cnt   <= r_cnt + 3'd1;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_gnt_d)      r_starve <= !if_req ? 4'd0 : ((r_starve == SLIM) ? SLIM : r_starve + 4'd1);
      else if (w_gnt_i) r_starve <= 4'd0;
    end
  end

  assign if_gnt    = w_gnt_i;
  assign d_gnt     = w_gnt_d;
  assign mem_en    = w_gnt_i || w_gnt_d;
  assign mem_we    = w_gnt_d && d_we;
  assign mem_be    = w_gnt_d ? d_be    : (w_gnt_i ? 4'hF    : 4'h0);
  assign mem_addr  = w_gnt_d ? d_addr  : (w_gnt_i ? if_addr : 32'h0);
  assign mem_wdata = w_gnt_d ? d_wdata : 32'h0;

  // Flush in the response cycle itself still suppresses the fetch data.
  assign if_rvalid = w_resp && !r_own_d && !r_kill && !if_flush;
  assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
  assign d_rvalid  = w_resp && r_own_d;
  assign d_rdata   = (d_rvalid && !r_we) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: three instances (MEM_LATENCY 1,2,3), a cycle-level reference model and directed scenarios.
module tb_mem_port_arbiter;
  localparam int N  = 3;
  localparam int SL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]        rst, if_req, if_flush, d_req, d_we;
  logic [N-1:0][31:0]  if_addr, d_addr, d_wdata, mem_rdata;
  logic [N-1:0][3:0]   d_be;
  logic [N-1:0]        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [N-1:0][31:0]  if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [N-1:0][3:0]   mem_be;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_port_arbiter #(.MEM_LATENCY(g + 1), .STARVE_LIMIT(SL)) u_dut (
      .clk(clk), .rst(rst[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_flush(if_flush[g]),
      .if_gnt(if_gnt[g]), .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_be(d_be[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_be(mem_be[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] @cyc %0d: got %h expected %h", nm, inst, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory behind each instance: byte-masked writes, reads return MEM_LATENCY cycles after the strobe.
  logic [31:0] mem [N][256];
  logic [7:0]  rd_addr [N];
  int          rd_due  [N];
  bit          rd_vld  [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      for (int w = 0; w < 256; w++) mem[i][w] = 32'h0;
      mem[i][1] = 32'h0010_0093;
      mem[i][2] = 32'h1234_5678;
      rd_vld[i] = 1'b0;
      rd_due[i] = 0;
      rd_addr[i] = 8'h0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (mem_en[i]) begin
        rd_vld[i]  <= 1'b1;
        rd_addr[i] <= mem_addr[i][9:2];
        rd_due[i]  <= cyc + i + 1;
        if (mem_we[i])
          for (int b = 0; b < 4; b++)
            if (mem_be[i][b]) mem[i][mem_addr[i][9:2]][8*b +: 8] <= mem_wdata[i][8*b +: 8];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      mem_rdata[i] = (rd_vld[i] && cyc == rd_due[i]) ? mem[i][rd_addr[i]] : 32'hA5A5_5A5A;
  end

  // Reference model: a pending transaction is described by its owner and the cycle its response is due.
  bit m_pend [N];
  int m_resp_at [N];
  bit m_own_d [N];
  bit m_we [N];
  bit m_kill [N];
  int m_starve [N];

  initial for (int i = 0; i < N; i++) begin
    m_pend[i] = 0; m_resp_at[i] = 0; m_own_d[i] = 0; m_we[i] = 0; m_kill[i] = 0; m_starve[i] = 0;
  end

  always @(negedge clk) begin
    bit busy, resp, gd, gf, fok, e_irv, e_drv;
    logic [31:0] e_ird, e_drd, e_addr, e_wdata;
    logic [3:0] e_be;
    logic e_we;
    for (int i = 0; i < N; i++) begin
      gd = 0; gf = 0; resp = 0; e_irv = 0; e_drv = 0;
      e_ird = 0; e_drd = 0; e_addr = 0; e_wdata = 0; e_be = 0; e_we = 0;
      if (rst[i]) begin
        m_pend[i] = 0; m_starve[i] = 0; m_kill[i] = 0;
      end else begin
        busy = m_pend[i];
        fok  = if_req[i] && !if_flush[i];
        if (!busy) begin
          if (d_req[i] && (!fok || m_starve[i] != SL)) gd = 1;
          else if (fok) gf = 1;
        end
        resp = busy && (cyc == m_resp_at[i]);
        if (resp && m_own_d[i]) begin
          e_drv = 1;
          e_drd = m_we[i] ? 32'h0 : mem_rdata[i];
        end
        if (resp && !m_own_d[i] && !m_kill[i] && !if_flush[i]) begin
          e_irv = 1;
          e_ird = mem_rdata[i];
        end
        if (gd) begin
          e_we = d_we[i]; e_be = d_be[i]; e_addr = d_addr[i]; e_wdata = d_wdata[i];
        end else if (gf) begin
          e_be = 4'hF; e_addr = if_addr[i];
        end
        if (resp) m_pend[i] = 0;
        else if (busy && !m_own_d[i] && if_flush[i]) m_kill[i] = 1;
        if (gd || gf) begin
          m_pend[i] = 1; m_resp_at[i] = cyc + i + 1; m_own_d[i] = gd;
          m_we[i] = gd && d_we[i]; m_kill[i] = 0;
        end
        if (gd) m_starve[i] = if_req[i] ? ((m_starve[i] >= SL) ? SL : m_starve[i] + 1) : 0;
        else if (gf) m_starve[i] = 0;
      end
      chk("if_gnt", i, 32'(if_gnt[i]), 32'(gf));
      chk("d_gnt", i, 32'(d_gnt[i]), 32'(gd));
      chk("mem_en", i, 32'(mem_en[i]), 32'(gd || gf));
      chk("mem_we", i, 32'(mem_we[i]), 32'(e_we));
      chk("mem_be", i, 32'(mem_be[i]), 32'(e_be));
      chk("mem_addr", i, mem_addr[i], e_addr);
      chk("mem_wdata", i, mem_wdata[i], e_wdata);
      chk("if_rvalid", i, 32'(if_rvalid[i]), 32'(e_irv));
      chk("if_rdata", i, if_rdata[i], e_ird);
      chk("d_rvalid", i, 32'(d_rvalid[i]), 32'(e_drv));
      chk("d_rdata", i, d_rdata[i], e_drd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_ord [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int ord [10];
  int gcyc [10];
  int n;

  initial begin
    rst = '1; if_req = '1; d_req = '1; if_flush = '0; d_we = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("lit_rst_mem_en", i, 32'(mem_en[i]), 32'd0);
      chk("lit_rst_gnt", i, 32'(if_gnt[i] | d_gnt[i]), 32'd0);
    end
    tick(); tick();
    rst = '0; if_req = '0; d_req = '0;
    tick();

    // Single fetch at latency 1, held request shows the one-cycle gap before regrant.
    if_req[0] = 1; if_addr[0] = 32'h4;
    @(negedge clk);
    chk("lit_f_gnt", 0, 32'(if_gnt[0]), 32'd1);
    chk("lit_f_addr", 0, mem_addr[0], 32'h4);
    chk("lit_f_be", 0, 32'(mem_be[0]), 32'hF);
    tick();
    @(negedge clk);
    chk("lit_f_nogap", 0, 32'(if_gnt[0]), 32'd0);
    chk("lit_f_rvalid", 0, 32'(if_rvalid[0]), 32'd1);
    chk("lit_f_rdata", 0, if_rdata[0], 32'h0010_0093);
    tick();
    @(negedge clk);
    chk("lit_f_regrant", 0, 32'(if_gnt[0]), 32'd1);
    tick(); if_req[0] = 0;
    tick();

    // Store then load back through the byte mask.
    d_req[0] = 1; d_we[0] = 1; d_be[0] = 4'b0011; d_addr[0] = 32'h100; d_wdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("lit_st_we", 0, 32'(mem_we[0]), 32'd1);
    chk("lit_st_be", 0, 32'(mem_be[0]), 32'h3);
    chk("lit_st_wdata", 0, mem_wdata[0], 32'hDEAD_BEEF);
    tick(); d_req[0] = 0;
    @(negedge clk);
    chk("lit_st_ack", 0, 32'(d_rvalid[0]), 32'd1);
    chk("lit_st_rdata", 0, d_rdata[0], 32'h0);
    tick(); d_req[0] = 1; d_we[0] = 0; d_be[0] = 4'h0;
    @(negedge clk);
    chk("lit_ld_gnt", 0, 32'(d_gnt[0]), 32'd1);
    tick(); d_req[0] = 0;
    @(negedge clk);
    chk("lit_ld_rvalid", 0, 32'(d_rvalid[0]), 32'd1);
    chk("lit_ld_rdata", 0, d_rdata[0], 32'h0000_BEEF);
    tick();

    // Both ports hammering: fetch is forced through after every STARVE_LIMIT data grants.
    if_req[0] = 1; d_req[0] = 1; d_addr[0] = 32'h200; if_addr[0] = 32'h8;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((if_gnt[0] || d_gnt[0]) && n < 10) begin
        ord[n] = if_gnt[0] ? 1 : 0;
        gcyc[n] = k;
        n++;
      end
      tick();
    end
    if_req[0] = 0; d_req[0] = 0;
    chk("lit_sv_count", 0, 32'(n), 32'd10);
    for (int j = 0; j < 10 && j < n; j++) begin
      chk("lit_sv_order", j, 32'(ord[j]), 32'(exp_ord[j]));
      if (j > 0) chk("lit_sv_gap", j, 32'(gcyc[j] - gcyc[j-1]), 32'd2);
    end
    tick(); tick();

    // Latency 3: flush one cycle after the fetch grant kills its response.
    if_req[2] = 1; if_addr[2] = 32'h8;
    @(negedge clk);
    chk("lit_fl_gnt", 2, 32'(if_gnt[2]), 32'd1);
    tick(); if_flush[2] = 1;
    tick(); if_flush[2] = 0;
    tick();
    @(negedge clk);
    chk("lit_fl_killed", 2, 32'(if_rvalid[2]), 32'd0);
    chk("lit_fl_noearly", 2, 32'(if_gnt[2]), 32'd0);
    tick();
    @(negedge clk);
    chk("lit_fl_regrant", 2, 32'(if_gnt[2]), 32'd1);
    tick(); if_req[2] = 0;
    tick(); tick();
    @(negedge clk);
    chk("lit_fl_rvalid", 2, 32'(if_rvalid[2]), 32'd1);
    chk("lit_fl_rdata", 2, if_rdata[2], 32'h1234_5678);
    tick();

    // Flush while idle only blocks fetch for that cycle.
    if_req[2] = 1; if_flush[2] = 1;
    @(negedge clk);
    chk("lit_fi_gnt", 2, 32'(if_gnt[2]), 32'd0);
    chk("lit_fi_mem_en", 2, 32'(mem_en[2]), 32'd0);
    tick(); if_flush[2] = 0;
    @(negedge clk);
    chk("lit_fi_gnt_after", 2, 32'(if_gnt[2]), 32'd1);
    tick(); if_req[2] = 0;
    repeat (4) tick();

    // Latency 2: reset mid-transaction drops the response and clears the starve count.
    if_req[1] = 1; d_req[1] = 1; d_we[1] = 0; d_addr[1] = 32'h4; if_addr[1] = 32'hC;
    @(negedge clk);
    chk("lit_rs_gnt0", 1, 32'(d_gnt[1]), 32'd1);
    repeat (6) tick();
    @(negedge clk);
    chk("lit_rs_gnt_t", 1, 32'(d_gnt[1]), 32'd1);
    tick(); rst[1] = 1;
    @(negedge clk);
    chk("lit_rs_gnt", 1, 32'(d_gnt[1] | if_gnt[1]), 32'd0);
    chk("lit_rs_mem_en", 1, 32'(mem_en[1]), 32'd0);
    chk("lit_rs_rvalid", 1, 32'(d_rvalid[1] | if_rvalid[1]), 32'd0);
    tick(); rst[1] = 0;
    @(negedge clk);
    chk("lit_rs_dropped", 1, 32'(d_rvalid[1]), 32'd0);
    chk("lit_rs_first_gnt", 1, 32'(d_gnt[1]), 32'd1);
    repeat (12) tick();
    @(negedge clk);
    chk("lit_rs_fetch5", 1, 32'(if_gnt[1]), 32'd1);
    tick(); if_req[1] = 0; d_req[1] = 0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
